// File: rtl/multiword_add_pkg.sv
// Shared constants and state encoding for the multi-word sequential adder.
package multiword_add_pkg;

  localparam int W_DEF         = 4;
  localparam int MAX_WORDS_DEF = 8;

  typedef enum logic {
    ST_FIRST = 1'b0,
    ST_MID   = 1'b1
  } state_e;

endpackage

// File: rtl/multiword_add_seq_rca.sv
// Combinational W-bit ripple-carry adder built from 1-bit full-adder cells.
// No registers; carry ripples LSB to MSB.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module rca_w #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  logic [W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < W; i++) begin : g_bit
    fa_cell u_fa (
      .a  (x[i]),
      .b  (y[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign co = c[W];
endmodule

// File: rtl/multiword_add_seq.sv
// Streaming multi-word adder: LSW-first operand pairs, carry chained between words.
// Latency: 1 cycle (registered output), full throughput of one word per clock.
// Backpressure: in_ready = ~out_valid | out_ready; output fields hold while stalled.
module multiword_add_seq
  import multiword_add_pkg::*;
#(
  parameter int W         = W_DEF,
  parameter int MAX_WORDS = MAX_WORDS_DEF,
  localparam int IDXW     = $clog2(MAX_WORDS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_x,
  input  logic [W-1:0]    in_y,
  input  logic            in_ci,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_s,
  output logic            out_co,
  output logic            out_last,
  output logic [IDXW-1:0] out_idx,
  output logic            out_err
);

  state_e          state;
  logic [IDXW-1:0] idx_q;
  logic            carry_q;

  logic            accept;
  logic            cin;
  logic            trunc;
  logic            pkt_end;
  logic [W-1:0]    sum;
  logic            cout;

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  // The stored carry is only meaningful inside a packet; first words take the packet carry-in.
  assign cin      = (state == ST_FIRST) ? in_ci : carry_q;
  assign trunc    = (idx_q == IDXW'(MAX_WORDS - 1)) & ~in_last;
  assign pkt_end  = in_last | trunc;

  rca_w #(.W(W)) u_rca (
    .x  (in_x),
    .y  (in_y),
    .ci (cin),
    .s  (sum),
    .co (cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_FIRST;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      out_valid <= 1'b0;
      out_s     <= '0;
      out_co    <= 1'b0;
      out_last  <= 1'b0;
      out_idx   <= '0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_s     <= sum;
      out_co    <= cout;
      out_idx   <= idx_q;
      out_last  <= pkt_end;
      out_err   <= trunc;
      carry_q   <= cout;
      if (pkt_end) begin
        state <= ST_FIRST;
        idx_q <= '0;
      end else begin
        state <= ST_MID;
        idx_q <= idx_q + IDXW'(1);
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Scoreboard bench for multiword_add_seq (W=4, MAX_WORDS=4) with directed vectors.
module tb_multiword_add_seq;

  typedef struct packed {
    logic [3:0] s;
    logic       co;
    logic       last;
    logic [1:0] idx;
    logic       err;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_x = '0;
  logic [3:0] in_y = '0;
  logic       in_ci = 1'b0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] out_s;
  logic       out_co;
  logic       out_last;
  logic [1:0] out_idx;
  logic       out_err;

  res_t        sb[$];
  int unsigned stamps[$];
  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  multiword_add_seq #(.W(4), .MAX_WORDS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_ci     (in_ci),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_co    (out_co),
    .out_last  (out_last),
    .out_idx   (out_idx),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic res_t mk(input logic [3:0] s, input logic co, input logic last,
                              input logic [1:0] idx, input logic err);
    mk = {s, co, last, idx, err};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Presents one word and waits for the handshake; the expected result is queued on accept.
  task automatic send(input logic [3:0] x, input logic [3:0] y, input logic ci,
                      input logic last, input res_t e, output int waits);
    bit done;
    done = 0;
    waits = 0;
    in_x = x; in_y = y; in_ci = ci; in_last = last; in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        done = 1;
      end else begin
        waits++;
        if (waits > 50) begin
          n_chk++; n_fail++;
          $display("FAIL accept_timeout: actual=no_accept expected=accept");
          done = 1;
        end
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain_empty", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  // Monitor: a result is consumed at the next rising edge whenever valid & ready at the falling edge.
  initial begin
    res_t got;
    res_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        got = {out_s, out_co, out_last, out_idx, out_err};
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_output: actual=%0h expected=none", got);
        end else begin
          e = sb.pop_front();
          chk("result{s,co,last,idx,err}", got, e);
          stamps.push_back(cyc);
        end
      end
    end
  end

  logic [3:0] sx[8]  = '{4'hA, 4'hF, 4'h8, 4'h7, 4'h0, 4'hC, 4'hE, 4'h6};
  logic [3:0] sy[8]  = '{4'h5, 4'hF, 4'h8, 4'h9, 4'h0, 4'h3, 4'h1, 4'h6};
  logic       sci[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [3:0] ss[8]  = '{4'hF, 4'hF, 4'h0, 4'h1, 4'h1, 4'hF, 4'h0, 4'hC};
  logic       sco[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    int w;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fields", {out_s, out_co, out_last, out_idx, out_err}, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // single-word packet
    send(4'h1, 4'h2, 1'b0, 1'b1, mk(4'h3, 0, 1, 2'd0, 0), w);

    // 0xFF + 0x01 across two words; ci on the second word must be ignored
    send(4'hF, 4'h1, 1'b0, 1'b0, mk(4'h0, 1, 0, 2'd0, 0), w);
    send(4'hF, 4'h0, 1'b0, 1'b1, mk(4'h0, 1, 1, 2'd1, 0), w);
    drain();

    // backpressure: pending result must hold and block input
    out_ready = 1'b0;
    send(4'h5, 4'h6, 1'b1, 1'b1, mk(4'hC, 0, 1, 2'd0, 0), w);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_fields", {out_s, out_co, out_last, out_idx, out_err}, mk(4'hC, 0, 1, 2'd0, 0));
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(4'h3, 4'h4, 1'b0, 1'b1, mk(4'h7, 0, 1, 2'd0, 0), w);
    chk("bp_release_wait", w, 0);
    drain();

    // streaming: eight single-word packets back to back
    stamps.delete();
    for (int i = 0; i < 8; i++) begin
      send(sx[i], sy[i], sci[i], 1'b1, mk(ss[i], sco[i], 1, 2'd0, 0), w);
      chk("stream_wait", w, 0);
    end
    drain();
    chk("stream_count", stamps.size(), 8);
    for (int i = 1; i < stamps.size(); i++)
      chk("stream_consecutive", stamps[i] - stamps[i-1], 1);

    // reset mid-packet discards the pending word and the stored carry
    out_ready = 1'b0;
    send(4'hF, 4'hF, 1'b0, 1'b0, mk(4'hE, 1, 0, 2'd0, 0), w);
    chk("pre_reset_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(4'h1, 4'h1, 1'b0, 1'b1, mk(4'h2, 0, 1, 2'd0, 0), w);

    // truncation at MAX_WORDS, then a fresh packet sampling in_ci=0
    send(4'hF, 4'h0, 1'b1, 1'b0, mk(4'h0, 1, 0, 2'd0, 0), w);
    send(4'hF, 4'h0, 1'b1, 1'b0, mk(4'h0, 1, 0, 2'd1, 0), w);
    send(4'hF, 4'h0, 1'b1, 1'b0, mk(4'h0, 1, 0, 2'd2, 0), w);
    send(4'hF, 4'h0, 1'b1, 1'b0, mk(4'h0, 1, 1, 2'd3, 1), w);
    send(4'hF, 4'h0, 1'b0, 1'b0, mk(4'hF, 0, 0, 2'd0, 0), w);
    send(4'h1, 4'h1, 1'b1, 1'b1, mk(4'h2, 0, 1, 2'd1, 0), w);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
